rr_arb_mux: RTL

Multi-channel round-robin arbiter fused with a one-hot payload mux and a single registered output stage.
Each of CH_N producers presents payload with a valid/ready handshake. One channel is granted per accepted beat, fairly. The winning payload is delivered downstream with one-cycle latency.
Sits between multiple request sources (e.g. bus masters, port queues) and a single shared consumer.

---
 rtl/rr_arb_mux_pkg.sv | 9 +
 rtl/one_hot_mux.sv | 18 +
 rtl/rr_arb_mux_arbiter.sv | 25 ++
 rtl/rr_arb_mux.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the rr_arb_mux round-robin arbiter/mux slice.
package rr_arb_mux_pkg;

  // Increment an index modulo n (n >= 1).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/one_hot_mux.sv
// AND-OR payload selector driven by a one-hot (or all-zero) select.
module one_hot_mux #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(N); i++) begin
      dout = dout | (din[i] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/rr_arb_mux_arbiter.sv
// Masked-priority round-robin grant: lowest request at or above ptr, else lowest overall.
module rr_arb_mux_arbiter #(
  parameter int unsigned CH_N  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [CH_N-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [CH_N-1:0]  gnt
);

  logic [CH_N-1:0] mask;
  logic [CH_N-1:0] masked;

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(CH_N); i++) begin
      mask[i] = (PTR_W'(i) >= ptr);
    end
    masked = req & mask;
    // x & -x isolates the lowest set bit
    if (|masked) gnt = masked & (~masked + CH_N'(1));
    else         gnt = req & (~req + CH_N'(1));
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter + one-hot payload mux with a single registered output stage.
// Optional packet locking (in_last/out_last) enabled by RR_ARB_MUX_LOCK_EN.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned CH_N  = 4,
  parameter int unsigned PLD_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CH_N-1:0]            in_valid,
  output logic [CH_N-1:0]            in_ready,
  input  logic [CH_N-1:0][PLD_W-1:0] in_pld,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PLD_W-1:0]           out_pld,
  output logic [CH_N-1:0]            out_sel
`ifdef RR_ARB_MUX_LOCK_EN
  ,
  input  logic [CH_N-1:0]            in_last,
  output logic                       out_last
`endif
);

  localparam int unsigned PTR_W = $clog2(CH_N);

  logic             out_valid_q, out_valid_d;
  logic [PLD_W-1:0] out_pld_q, out_pld_d;
  logic [CH_N-1:0]  out_sel_q, out_sel_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic             can_load;
  logic             xfer;
  logic             last_beat;
  logic [CH_N-1:0]  arb_gnt;
  logic [CH_N-1:0]  gnt;
  logic [PLD_W-1:0] mux_pld;
  logic [PTR_W-1:0] gnt_idx;

`ifdef RR_ARB_MUX_LOCK_EN
  logic lock_q, lock_d;
  logic out_last_q, out_last_d;
`endif

  rr_arb_mux_arbiter #(
    .CH_N  (CH_N),
    .PTR_W (PTR_W)
  ) u_arbiter (
    .req (in_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  one_hot_mux #(
    .N (CH_N),
    .W (PLD_W)
  ) u_mux (
    .sel  (gnt),
    .din  (in_pld),
    .dout (mux_pld)
  );

  // While locked, out_sel_q still names the channel owning the packet.
  always_comb begin
    gnt = arb_gnt;
`ifdef RR_ARB_MUX_LOCK_EN
    if (lock_q) gnt = in_valid & out_sel_q;
`endif
  end

`ifdef RR_ARB_MUX_LOCK_EN
  assign last_beat = |(in_last & gnt);
`else
  assign last_beat = 1'b1;
`endif

  // Handshake is suppressed during reset so no producer sees a dropped beat as accepted.
  assign can_load = ~out_valid_q | out_ready;
  assign in_ready = gnt & {CH_N{can_load & rst_n}};
  assign xfer     = |in_ready;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < int'(CH_N); i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pld_d   = out_pld_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_pld_d   = mux_pld;
      out_sel_d   = gnt;
      if (last_beat) ptr_d = PTR_W'(wrap_inc(32'(gnt_idx), CH_N));
`ifdef RR_ARB_MUX_LOCK_EN
      lock_d      = ~last_beat;
      out_last_d  = last_beat;
`endif
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pld_q   <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_pld_q   <= out_pld_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_pld   = out_pld_q;
  assign out_sel   = out_sel_q;
`ifdef RR_ARB_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
